// File: rtl/pushsw_conditioner_pkg.sv
// Shared constants and helpers for the push-switch conditioner.
// Vector width, default debounce length, counter width and a priority encoder.
package pushsw_conditioner_pkg;

    localparam int PUSHSW_W       = 6;
    localparam int DB_CNT_DEFAULT = 50000;
    localparam int CNT_W          = 16;

    typedef logic [PUSHSW_W-1:0] sw_vec_t;

    // Keeps only the highest-index set bit of v; ascending scan so the last hit wins.
    function automatic sw_vec_t highest_onehot(input sw_vec_t v);
        highest_onehot = '0;
        for (int i = 0; i < PUSHSW_W; i++) begin
            if (v[i]) begin
                highest_onehot    = '0;
                highest_onehot[i] = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/pushsw_conditioner_debounce_cell.sv
// One-bit switch conditioner: 2-flop synchronizer, stability counter,
// debounced state flop and a registered rising-edge press pulse.
module debounce_cell
    import pushsw_conditioner_pkg::*;
#(
    parameter int DB_CNT = DB_CNT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic state,
    output logic pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

    logic             sync1;
    logic             sync2;
    logic             state_d;
    logic [CNT_W-1:0] cnt;

    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // blocking here would collapse the synchronizer into a single stage.
    // NOTE: the synchronizer flops are reset too, so a switch held through
    // reset must requalify from scratch instead of leaking a stale level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            state   <= 1'b0;
            state_d <= 1'b0;
            pulse   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            state_d <= state;
            pulse   <= state & ~state_d;
            if (sync2 == state) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // This edge completes DB_CNT consecutive mismatching cycles.
                cnt   <= '0;
                state <= ~state;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pushsw_conditioner.sv
// Six-switch debounce/press-strobe front end for the mode selector.
// Define PUSHSW_HOLD_EN to make pushsw_input a latched one-hot of the last press.
module pushsw_conditioner
    import pushsw_conditioner_pkg::*;
#(
    parameter int DB_CNT = DB_CNT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PUSHSW_W-1:0] pushsw_raw,
    output logic [PUSHSW_W-1:0] pushsw_input,
    output logic [PUSHSW_W-1:0] pushsw_pulse,
    output logic                pushsw_valid
);

    sw_vec_t debounced;

    for (genvar i = 0; i < PUSHSW_W; i++) begin : g_cell
        debounce_cell #(
            .DB_CNT(DB_CNT)
        ) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (pushsw_raw[i]),
            .state(debounced[i]),
            .pulse(pushsw_pulse[i])
        );
    end

    assign pushsw_valid = |pushsw_pulse;

`ifdef PUSHSW_HOLD_EN
    sw_vec_t hold_q;

    // Latch the winning press; re-pressing the held bit reloads the same value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (pushsw_valid) begin
            hold_q <= highest_onehot(pushsw_pulse);
        end
    end

    assign pushsw_input = hold_q;
`else
    assign pushsw_input = debounced;
`endif

endmodule

// File: tb/tb_pushsw_conditioner.sv
// Self-checking bench for pushsw_conditioner with DB_CNT = 4: directed table,
// hand-written corner sequences, then random stimulus against a history-window model.
module tb_pushsw_conditioner;

    localparam int DB = 4;
    localparam int W  = 6;

`ifdef PUSHSW_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [W-1:0] pushsw_raw;
    logic [W-1:0] pushsw_input;
    logic [W-1:0] pushsw_pulse;
    logic         pushsw_valid;

    int total = 0;
    int bad   = 0;

    pushsw_conditioner #(.DB_CNT(DB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pushsw_raw  (pushsw_raw),
        .pushsw_input(pushsw_input),
        .pushsw_pulse(pushsw_pulse),
        .pushsw_valid(pushsw_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: debounced bit flips once the last DB synchronized
    // samples all disagree with it; synchronizer is a two-deep delay.
    logic [W-1:0] m_s1, m_s2, m_deb, m_deb_prev, m_pulse, m_hold;
    logic [W-1:0] m_hist [DB];

    function automatic logic [W-1:0] top_bit(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) begin
                r[i] = 1'b1;
                break;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_deb_prev = '0; m_pulse = '0; m_hold = '0;
        for (int j = 0; j < DB; j++) m_hist[j] = '0;
    endtask

    task automatic model_step(input logic [W-1:0] raw);
        logic [W-1:0] mis;
        logic [W-1:0] new_pulse;
        for (int j = DB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = m_s2;
        mis = '1;
        for (int j = 0; j < DB; j++) mis &= m_hist[j] ^ m_deb;
        new_pulse = m_deb & ~m_deb_prev;
        if (m_pulse != '0) m_hold = top_bit(m_pulse);
        m_deb_prev = m_deb;
        m_deb      = m_deb ^ mis;
        m_s2       = m_s1;
        m_s1       = raw;
        m_pulse    = new_pulse;
    endtask

    function automatic logic [W-1:0] model_input();
        return HOLD ? m_hold : m_deb;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Apply raw, clock once, update model, then sample away from the edge.
    task automatic step(input logic [W-1:0] raw);
        pushsw_raw = raw;
        @(posedge clk);
        if (rst_n) model_step(raw);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        pushsw_raw = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [W-1:0] raw;
        logic [W-1:0] exp_in;
        logic [W-1:0] exp_pulse;
        logic         exp_valid;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int           pulses;
        logic [W-1:0] raw_r;

        // Clean press of bit 3 held 8 cycles, then release (rows are cycles 1..15).
        for (int k = 1; k <= 15; k++) begin
            tbl[k-1].raw       = (k <= 8) ? 6'b001000 : 6'b000000;
            tbl[k-1].exp_pulse = (k == 7) ? 6'b001000 : 6'b000000;
            tbl[k-1].exp_valid = (k == 7);
            if (HOLD) tbl[k-1].exp_in = (k >= 8) ? 6'b001000 : 6'b000000;
            else      tbl[k-1].exp_in = (k >= 6 && k <= 13) ? 6'b001000 : 6'b000000;
        end

        rst_n      = 1'b0;
        pushsw_raw = '0;
        model_reset();
        #1;
        check("reset_input", pushsw_input, '0);
        check("reset_pulse", pushsw_pulse, '0);
        check("reset_valid", {5'b0, pushsw_valid}, '0);
        do_reset();

        for (int k = 0; k < 15; k++) begin
            step(tbl[k].raw);
            check($sformatf("tbl_input_c%0d", k + 1), pushsw_input, tbl[k].exp_in);
            check($sformatf("tbl_pulse_c%0d", k + 1), pushsw_pulse, tbl[k].exp_pulse);
            check($sformatf("tbl_valid_c%0d", k + 1), {5'b0, pushsw_valid}, {5'b0, tbl[k].exp_valid});
        end

        // Bounce on bit 0: three cycles high is shorter than qualification.
        do_reset();
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step((k < 3) ? 6'b000001 : 6'b000000);
            pulses += int'(pushsw_valid);
            check("bounce_input", pushsw_input, '0);
        end
        check("bounce_pulses", W'(pulses), '0);

        // Simultaneous press of bits 5 and 1.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            step(6'b100010);
            if (k == 7) check("simul_pulse", pushsw_pulse, 6'b100010);
            if (k == 8 && HOLD) check("simul_hold", pushsw_input, 6'b100000);
            if (k == 8 && !HOLD) check("simul_deb", pushsw_input, 6'b100010);
        end
        for (int k = 0; k < 8; k++) step('0);
        check("simul_after_release", pushsw_input, HOLD ? 6'b100000 : 6'b000000);

        // Press bit 2, release, then press bit 4.
        do_reset();
        for (int k = 0; k < 8; k++) step(6'b000100);
        check("seq_first", pushsw_input, 6'b000100);
        for (int k = 0; k < 8; k++) step('0);
        check("seq_between", pushsw_input, HOLD ? 6'b000100 : 6'b000000);
        for (int k = 0; k < 8; k++) step(6'b010000);
        check("seq_second", pushsw_input, 6'b010000);

        // Long hold of bit 1: a single pulse, no pulse on release.
        do_reset();
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            step(6'b000010);
            pulses += int'(pushsw_pulse[1]);
        end
        check("hold_one_pulse", W'(pulses), W'(1));
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            step('0);
            pulses += int'(pushsw_valid);
            if (!HOLD && k == 5) check("release_c5", pushsw_input, 6'b000010);
            if (!HOLD && k == 6) check("release_c6", pushsw_input, 6'b000000);
        end
        check("release_no_pulse", W'(pulses), '0);

        // Reset mid-qualification with bit 4 held.
        do_reset();
        for (int k = 0; k < 4; k++) step(6'b010000);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_input", pushsw_input, '0);
        check("midrst_pulse", pushsw_pulse, '0);
        for (int k = 0; k < 2; k++) begin
            step(6'b010000);
            check("midrst_hold_input", pushsw_input, '0);
            check("midrst_hold_valid", {5'b0, pushsw_valid}, '0);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step(6'b010000);
            check($sformatf("midrst_pulse_c%0d", k), pushsw_pulse, (k == 7) ? 6'b010000 : 6'b000000);
        end

        // Random stimulus against the model; per-bit flips keep runs near DB.
        do_reset();
        raw_r = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 5) == 0) raw_r[i] = ~raw_r[i];
            end
            step(raw_r);
            check("rand_input", pushsw_input, model_input());
            check("rand_pulse", pushsw_pulse, m_pulse);
            check("rand_valid", {5'b0, pushsw_valid}, {5'b0, |m_pulse});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
